// File: rtl/effect_arbiter_pkg.sv
// Shared definitions for the effect arbiter: sample/amount widths and FSM encoding.
package effect_arbiter_pkg;

    localparam int SAMPLE_W = 12;
    localparam int AMOUNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

endpackage

// File: rtl/effect_arbiter_rr_grant.sv
// Round-robin grant: first pending channel strictly after last_grant, wrapping modulo N_CH.
module rr_grant #(
    parameter int N_CH = 4,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] pending,
    input  logic [CH_W-1:0] last_grant,
    output logic [N_CH-1:0] grant,
    output logic            valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last_grant) + i) % N_CH;
            if (!valid && pending[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/effect_arbiter.sv
// Shares one external limiter between N_CH sample channels; each channel buffers one
// pending sample, requests are served round-robin and results come back one-hot.
module effect_arbiter
    import effect_arbiter_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_CH-1:0]            req,
    input  logic [SAMPLE_W*N_CH-1:0]   sample_in,
    input  logic [AMOUNT_W*N_CH-1:0]   amount_in,
    input  logic                       clear_err,
    output logic                       eff_ready,
    output logic signed [SAMPLE_W-1:0] eff_sample,
    output logic [AMOUNT_W-1:0]        eff_amount,
    input  logic                       eff_done,
    input  logic signed [SAMPLE_W-1:0] eff_result,
    output logic [N_CH-1:0]            out_valid,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic                       busy,
    output logic [N_CH-1:0]            overrun,
    output logic                       timeout_err
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t                     state;
    logic [N_CH-1:0]            pending;
    logic [CH_W-1:0]            last_grant;
    logic [N_CH-1:0]            cur_grant;
    logic [CH_W-1:0]            cur_idx;
    logic [TO_W-1:0]            wait_cnt;
    logic signed [SAMPLE_W-1:0] sample_buf [N_CH];
    logic [AMOUNT_W-1:0]        amount_buf [N_CH];

    logic [N_CH-1:0] grant;
    logic            grant_valid;
    logic [CH_W-1:0] grant_idx;
    logic [N_CH-1:0] grant_clear;
    logic [N_CH-1:0] pending_next;
    logic [N_CH-1:0] overrun_hit;
    logic            done_accept;
    logic            timeout_hit;

    rr_grant #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_grant (
        .pending    (pending),
        .last_grant (last_grant),
        .grant      (grant),
        .valid      (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant[k]) begin
                grant_idx = CH_W'(k);
            end
        end
    end

    // A request on the channel being granted this cycle re-arms it without counting as overrun.
    always_comb begin
        grant_clear  = (state == ST_IDLE && grant_valid) ? grant : '0;
        overrun_hit  = req & pending & ~grant_clear;
        pending_next = (pending & ~grant_clear) | req;
        done_accept  = (state == ST_WAIT) && eff_done && (wait_cnt != TO_W'(1));
        timeout_hit  = (state == ST_WAIT) && !done_accept && (wait_cnt == TO_W'(TIMEOUT));
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        for (int k = 0; k < N_CH; k++) begin
            if (req[k]) begin
                sample_buf[k] <= sample_in[SAMPLE_W*k +: SAMPLE_W];
                amount_buf[k] <= amount_in[AMOUNT_W*k +: AMOUNT_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            pending     <= '0;
            last_grant  <= CH_W'(N_CH - 1);
            cur_grant   <= '0;
            cur_idx     <= '0;
            wait_cnt    <= '0;
            eff_ready   <= 1'b0;
            eff_sample  <= '0;
            eff_amount  <= '0;
            out_valid   <= '0;
            out_sample  <= '0;
            overrun     <= '0;
            timeout_err <= 1'b0;
        end else begin
            pending     <= pending_next;
            overrun     <= (clear_err ? '0 : overrun) | overrun_hit;
            timeout_err <= (timeout_err & ~clear_err) | timeout_hit;
            case (state)
                ST_IDLE: begin
                    out_valid <= '0;
                    if (grant_valid) begin
                        eff_sample <= sample_buf[grant_idx];
                        eff_amount <= amount_buf[grant_idx];
                        cur_grant  <= grant;
                        cur_idx    <= grant_idx;
                        eff_ready  <= 1'b1;
                        wait_cnt   <= TO_W'(1);
                        state      <= ST_WAIT;
                    end
                end
                // The first WAIT cycle may still see done left over from the previous job.
                ST_WAIT: begin
                    if (done_accept || timeout_hit) begin
                        out_sample <= done_accept ? eff_result : eff_sample;
                        out_valid  <= cur_grant;
                        eff_ready  <= 1'b0;
                        state      <= ST_DELIVER;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                ST_DELIVER: begin
                    out_valid  <= '0;
                    last_grant <= cur_idx;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_effect_arbiter.sv
// Directed bench for effect_arbiter with a scoreboard monitor and a behavioural limiter.
module tb_effect_arbiter;

    localparam int N_CH    = 4;
    localparam int TIMEOUT = 16;

    logic                clock;
    logic                reset;
    logic [N_CH-1:0]     req;
    logic [12*N_CH-1:0]  sample_in;
    logic [2*N_CH-1:0]   amount_in;
    logic                clear_err;
    logic                eff_ready;
    logic signed [11:0]  eff_sample;
    logic [1:0]          eff_amount;
    logic                eff_done;
    logic signed [11:0]  eff_result;
    logic [N_CH-1:0]     out_valid;
    logic signed [11:0]  out_sample;
    logic                busy;
    logic [N_CH-1:0]     overrun;
    logic                timeout_err;

    typedef struct {
        int ch_mask;
        int value;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rdy_cnt  = 0;
    int   lim_mode = 0;   // 0: answers on 2nd ready cycle, 1: never answers, 2: done stuck high
    int   n;

    effect_arbiter #(
        .N_CH    (N_CH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .sample_in   (sample_in),
        .amount_in   (amount_in),
        .clear_err   (clear_err),
        .eff_ready   (eff_ready),
        .eff_sample  (eff_sample),
        .eff_amount  (eff_amount),
        .eff_done    (eff_done),
        .eff_result  (eff_result),
        .out_valid   (out_valid),
        .out_sample  (out_sample),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Hard symmetric clip; the level is chosen by the amount setting.
    function automatic logic signed [11:0] limit(input logic signed [11:0] s, input logic [1:0] a);
        int lvl;
        case (a)
            2'd0:    lvl = 2047;
            2'd1:    lvl = 1844;
            2'd2:    lvl = 1536;
            default: lvl = 1024;
        endcase
        if (int'(s) > lvl) return 12'(lvl);
        if (int'(s) < -lvl) return 12'(-lvl);
        return s;
    endfunction

    initial begin
        eff_done   = 1'b0;
        eff_result = '0;
        forever begin
            @(posedge clock);
            #1;
            if (eff_ready) rdy_cnt++;
            else rdy_cnt = 0;
            case (lim_mode)
                0:       eff_done = (rdy_cnt >= 2);
                1:       eff_done = 1'b0;
                default: eff_done = 1'b1;
            endcase
            eff_result = limit(eff_sample, eff_amount);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (!reset && out_valid != '0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: out_valid=%b out_sample=%0d, expected no output",
                         out_valid, out_sample);
            end else begin
                mon_e = sb.pop_front();
                chk("out_valid", int'(out_valid), mon_e.ch_mask);
                chk("out_sample", int'(out_sample), mon_e.value);
                if (mon_e.cyc >= 0) chk("out_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int k, input int s, input int a);
        sample_in[12*k +: 12] = 12'(s);
        amount_in[2*k +: 2]   = 2'(a);
    endtask

    task automatic pulse(input logic [N_CH-1:0] m);
        req = m;
        tick();
        req = '0;
    endtask

    task automatic push(input int m, input int v, input int c);
        exp_t e;
        e.ch_mask = m;
        e.value   = v;
        e.cyc     = c;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 200) begin
            failures++;
            $display("FAIL %s_idle: outstanding=%0d busy=%0b after 200 cycles, expected 0/0",
                     name, sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_eff_ready"}, int'(eff_ready), 0);
        chk({tag, "_eff_sample"}, int'(eff_sample), 0);
        chk({tag, "_eff_amount"}, int'(eff_amount), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_sample"}, int'(out_sample), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        req       = '0;
        clear_err = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_vals(tag);
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        sample_in = '0;
        amount_in = '0;
        clear_err = 1'b0;

        // Single request, best-case latency
        do_reset("rst_single");
        set_ch(0, 2000, 3);
        push(1, 1024, cyc + 4);
        pulse(4'b0001);
        wait_idle("single");

        // All channels at once, served in channel order
        do_reset("rst_simul");
        set_ch(0, 100, 1);
        set_ch(1, -1900, 1);
        set_ch(2, 1600, 1);
        set_ch(3, 5, 1);
        push(1, 100, -1);
        push(2, -1844, -1);
        push(4, 1600, -1);
        push(8, 5, -1);
        pulse(4'b1111);
        wait_idle("simul");
        chk("simul_overrun", int'(overrun), 0);

        // Two strobes on channel 2 while channel 0 is being served
        do_reset("rst_overrun");
        set_ch(0, 10, 0);
        push(1, 10, -1);
        push(4, 400, -1);
        pulse(4'b0001);
        tick();
        set_ch(2, 300, 0);
        pulse(4'b0100);
        set_ch(2, 400, 0);
        pulse(4'b0100);
        wait_idle("overrun");
        chk("overrun_set", int'(overrun), 4);
        tick();
        chk("overrun_sticky", int'(overrun), 4);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("overrun_cleared", int'(overrun), 0);

        // Limiter never answers
        do_reset("rst_timeout");
        lim_mode = 1;
        set_ch(1, -50, 0);
        n = cyc;
        push(2, -50, n + 2 + TIMEOUT);
        pulse(4'b0010);
        repeat (TIMEOUT - 2) tick();
        chk("timeout_err_early", int'(timeout_err), 0);
        chk("timeout_ready_held", int'(eff_ready), 1);
        chk("timeout_sample_held", int'(eff_sample), -50);
        wait_idle("timeout");
        chk("timeout_err_set", int'(timeout_err), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("timeout_err_cleared", int'(timeout_err), 0);
        lim_mode = 0;

        // Done stuck high must not be taken in the first WAIT cycle
        do_reset("rst_stale");
        lim_mode = 2;
        set_ch(3, -2000, 3);
        push(8, -1024, cyc + 4);
        pulse(4'b1000);
        wait_idle("stale");
        lim_mode = 0;

        // Reset in the middle of WAIT drops the job and everything pending
        do_reset("rst_pre_mid");
        set_ch(1, 111, 0);
        set_ch(3, 222, 0);
        pulse(4'b1010);
        tick();
        chk("mid_busy", int'(busy), 1);
        chk("mid_eff_ready", int'(eff_ready), 1);
        chk("mid_eff_sample", int'(eff_sample), 111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("rst_mid");
        repeat (10) tick();
        chk("mid_pending_lost", int'(busy), 0);
        set_ch(2, -7, 2);
        push(4, -7, cyc + 4);
        pulse(4'b0100);
        wait_idle("after_reset");

        tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/effect_arbiter.md
EFFECT_ARBITER -- requirements
Module: effect_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of requesting sample channels.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles to wait for eff_done.
REQ-003 Clock and reset: reset reset, synchronous, active-high; clock clock.
REQ-004 clock  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req  input  N_CH  per-channel new-sample strobe, one cycle.
REQ-007 sample_in  input  12*N_CH  signed samples; channel k in bits [12k+11:12k].
REQ-008 amount_in  input  2*N_CH  per-channel limiting setting; channel k in bits [2k+1:2k].
REQ-009 clear_err  input  1  clears the sticky error flags.
REQ-010 eff_ready  output  1  request to the shared limiter; held high while waiting.
REQ-011 eff_sample  output  12  signed sample presented to the limiter.
REQ-012 eff_amount  output  2  limiting setting presented to the limiter.
REQ-013 eff_done  input  1  limiter result-valid level.
REQ-014 eff_result  input  12  signed limiter result.
REQ-015 out_valid  output  N_CH  one-hot result strobe, one cycle.
REQ-016 out_sample  output  12  signed result for the channel flagged in out_valid.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 overrun  output  N_CH  sticky: a pending sample was overwritten.
REQ-019 timeout_err  output  1  sticky: the limiter failed to answer within TIMEOUT.

Function
REQ-020 Each channel SHALL have a pending bit plus 12-bit sample and 2-bit amount buffers; req[k] SHALL load the buffers and set pending[k] at the clock edge.
REQ-021 req[k] arriving while pending[k] is already set SHALL overwrite the buffers, keep pending set, and set overrun[k].
REQ-022 The FSM SHALL have three states: IDLE, WAIT and DELIVER.
REQ-023 IDLE: if any pending bit is set, grant round-robin starting at last_grant+1 (modulo N_CH), copy the granted buffers to eff_sample and eff_amount, clear that pending bit, and go to WAIT; otherwise stay in IDLE.
REQ-024 A req for the channel being granted in the same cycle SHALL set pending again with the new data, with no overrun.
REQ-025 WAIT: eff_ready=1 and eff_sample and eff_amount stable; eff_done SHALL be ignored in the first WAIT cycle (stale level) and accepted from the second WAIT cycle onward.
REQ-026 When eff_done is accepted, capture eff_result and go to DELIVER.
REQ-027 If eff_done is not accepted by the TIMEOUT-th WAIT cycle, capture eff_sample unmodified, set timeout_err, and go to DELIVER.
REQ-028 DELIVER lasts one cycle: out_valid is one-hot on the granted channel, out_sample holds the captured value, last_grant is updated, and the FSM returns to IDLE.
REQ-029 out_valid and eff_ready SHALL be registered; out_sample and eff_sample SHALL hold their last values outside DELIVER and WAIT respectively.
REQ-030 Best-case latency from req to out_valid, with the system idle and the limiter answering in the second WAIT cycle, SHALL be 4 cycles.
REQ-031 clear_err SHALL clear overrun and timeout_err; if it coincides with a new error event, the set wins.
REQ-032 No arithmetic is performed on sample data; all samples pass through as 12-bit signed values.

Reset
REQ-033 Reset SHALL force: state=IDLE; pending=0; last_grant=N_CH-1 (so channel 0 has first priority); eff_ready=0; eff_sample=0; eff_amount=0; out_valid=0; out_sample=0; overrun=0; timeout_err=0.
REQ-034 Reset asserted mid-WAIT SHALL abandon the transaction with no out_valid, and all pending samples SHALL be lost.

Structure
REQ-035 The shared package SHALL hold the FSM state encoding, the sample width of 12, and the amount width of 2.
REQ-036 The round-robin grant logic SHALL be one sub-module, rr_grant (inputs: pending, last_grant; outputs: one-hot grant and valid).

Verification
REQ-037 The bench SHALL attach the limiter with a 2-cycle done latency and cover the following scenarios.
REQ-038 Single request: req[0] with sample 2000, amount 2'b11 -> exactly one out_valid=4'b0001 with out_sample 1024, 4 cycles after req.
REQ-039 Simultaneous requests: req=4'b1111 with samples 100, -1900, 1600, 5 and amount 2'b01 -> outputs in channel order 0,1,2,3 with values 100, -1844, 1600, 5, and overrun=0.
REQ-040 Overrun: two req[2] strobes during a busy period (samples 300, then 400) -> one output of 400 on channel 2, and overrun[2]=1 until clear_err.
REQ-041 Timeout: eff_done tied to 0 with req[1] sample -50 -> out_sample -50 on channel 1 after TIMEOUT WAIT cycles, and timeout_err=1.
REQ-042 Reset mid-WAIT: reset during WAIT -> no out_valid, all outputs at reset values the next cycle, and a subsequent req is served normally.
